// File: rtl/heartbeat_pkg.sv
// heartbeat_pkg: shared state type, ASCII constants and line-field offsets for heartbeat_reporter.
package heartbeat_pkg;

   typedef enum logic [1:0] {IDLE, CONV, EMIT} hb_state_e;

   localparam logic [7:0] ASC_SP   = 8'h20;
   localparam logic [7:0] ASC_DASH = 8'h2D;
   localparam logic [7:0] ASC_BANG = 8'h21;
   localparam logic [7:0] ASC_LF   = 8'h0A;
   localparam logic [7:0] ASC_0    = 8'h30;

   // Byte offsets counted from the end of the digit field; the message starts at F_MSG.
   localparam int F_SP0  = 0;
   localparam int F_DASH = 1;
   localparam int F_SP1  = 2;
   localparam int F_MSG  = 3;
   // Fixed bytes per line besides digits and message: " - " plus '!' plus LF.
   localparam int F_TAIL = 5;

   function automatic longint pow10(input int n);
      longint r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, one shift per clock.
//   start_i : load bin_i (starts a conversion, CNT_W shift cycles follow)
//   busy_o  : shifts still pending
//   done_o  : bcd_o holds the result of the last conversion
//   bcd_o   : DIGITS BCD nibbles, least significant digit in [3:0]
module bin2bcd_seq #(
   parameter int CNT_W  = 32,
   parameter int DIGITS = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic [CNT_W-1:0]      bin_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [4*DIGITS-1:0]   bcd_o
);

   localparam int SW = $clog2(CNT_W + 1);

   logic [CNT_W-1:0]    bin_q, bin_d;
   logic [4*DIGITS-1:0] bcd_q, bcd_d, adj;
   logic [SW-1:0]       sft_q, sft_d;
   logic                done_q, done_d;

   always_comb begin
      adj = bcd_q;
      for (int i = 0; i < DIGITS; i++)
         adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
      bin_d  = bin_q;
      bcd_d  = bcd_q;
      sft_d  = sft_q;
      done_d = done_q;
      if (start_i) begin
         bin_d  = bin_i;
         bcd_d  = '0;
         sft_d  = SW'(CNT_W);
         done_d = 1'b0;
      end else if (sft_q != '0) begin
         // Digits beyond DIGITS are shifted out; the caller guarantees the value fits.
         bcd_d  = {adj[4*DIGITS-2:0], bin_q[CNT_W-1]};
         bin_d  = bin_q << 1;
         sft_d  = sft_q - SW'(1);
         done_d = (sft_q == SW'(1));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_q  <= '0;
         bcd_q  <= '0;
         sft_q  <= '0;
         done_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         bcd_q  <= bcd_d;
         sft_q  <= sft_d;
         done_q <= done_d;
      end
   end

   assign busy_o = (sft_q != '0);
   assign done_o = done_q;
   assign bcd_o  = bcd_q;

endmodule

// File: rtl/heartbeat_reporter.sv
// heartbeat_reporter: cycle counter that streams "<count> - <msg>!\n" every PERIOD counts.
//   en                         : count enable (emission continues while low)
//   msg_data/msg_len           : message bytes (byte 0 first) and length, sampled on each event
//   out_valid/out_ready        : byte stream handshake; out_data is the byte, out_last marks LF
//   overrun                    : sticky, an event arrived while a line was still in progress
//   done                       : LIMIT reached and the final line has drained
//   cnt                        : current cycle count
module heartbeat_reporter
   import heartbeat_pkg::*;
#(
   parameter int PERIOD  = 200000,
   parameter int LIMIT   = 1000000,
   parameter int DIGITS  = 8,
   parameter int MSG_LEN = 16,
   parameter int CNT_W   = 32
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         en,
   input  logic [8*MSG_LEN-1:0]         msg_data,
   input  logic [$clog2(MSG_LEN+1)-1:0] msg_len,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [7:0]                   out_data,
   output logic                         out_last,
   output logic                         overrun,
   output logic                         done,
   output logic [CNT_W-1:0]             cnt
);

   localparam int LW = $clog2(MSG_LEN + 1);
   localparam int IW = $clog2(DIGITS + F_TAIL + MSG_LEN + 1);

   if (PERIOD < 1) begin : g_bad_period
      $error("heartbeat_reporter: PERIOD must be >= 1");
   end
   if (longint'(LIMIT) >= pow10(DIGITS)) begin : g_bad_limit
      $error("heartbeat_reporter: LIMIT does not fit in DIGITS decimal digits");
   end

   hb_state_e            state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, per_q;
   logic [IW-1:0]        idx_q, idx_d;
   logic [8*MSG_LEN-1:0] msg_q, msg_d;
   logic [LW-1:0]        len_q, len_d;
   logic                 ovr_q;

   logic                 inc, evt, start;
   logic                 bcd_busy, bcd_done;
   logic [4*DIGITS-1:0]  bcd, hi;
   logic [IW-1:0]        col, mi, bang_i;
   logic [3:0]           digit;
   logic                 blank;
   logic [7:0]           mbyte, byte_c;

   bin2bcd_seq #(.CNT_W(CNT_W), .DIGITS(DIGITS)) u_bcd (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (start),
      .bin_i   (cnt_q + CNT_W'(1)),
      .busy_o  (bcd_busy),
      .done_o  (bcd_done),
      .bcd_o   (bcd)
   );

   always_comb begin
      inc   = en && (cnt_q < CNT_W'(LIMIT));
      // The event edge is the one on which cnt becomes a multiple of PERIOD.
      evt   = inc && (per_q == CNT_W'(PERIOD - 1));
      start = evt && (state_q == IDLE);
      // Column idx shows nibble DIGITS-1-idx; it is blank when it and every higher nibble are zero.
      col    = IW'(DIGITS - 1) - idx_q;
      hi     = bcd >> {col, 2'b00};
      digit  = 4'(hi);
      blank  = (hi == '0) && (idx_q != IW'(DIGITS - 1));
      mi     = idx_q - IW'(DIGITS + F_MSG);
      mbyte  = 8'(msg_q >> {mi, 3'b000});
      bang_i = IW'(DIGITS + F_MSG) + IW'(len_q);
      byte_c = (idx_q < IW'(DIGITS))                                      ? (blank ? ASC_SP : ASC_0 + {4'h0, digit}) :
               (idx_q == IW'(DIGITS + F_SP0) || idx_q == IW'(DIGITS + F_SP1)) ? ASC_SP :
               (idx_q == IW'(DIGITS + F_DASH))                            ? ASC_DASH :
               (idx_q < bang_i)                                           ? mbyte :
               (idx_q == bang_i)                                          ? ASC_BANG : ASC_LF;
      out_valid = (state_q == EMIT);
      out_data  = out_valid ? byte_c : 8'h00;
      out_last  = out_valid && (idx_q == bang_i + IW'(1));
      done      = (cnt_q == CNT_W'(LIMIT)) && (state_q == IDLE);
      overrun   = ovr_q;
      cnt       = cnt_q;
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      msg_d   = msg_q;
      len_d   = len_q;
      if (start) begin
         state_d = CONV;
         msg_d   = msg_data;
         len_d   = (msg_len > LW'(MSG_LEN)) ? LW'(MSG_LEN) : msg_len;
      end else if (state_q == CONV && !bcd_busy && bcd_done) begin
         state_d = EMIT;
         idx_d   = '0;
      end else if (state_q == EMIT && out_ready) begin
         state_d = out_last ? IDLE : EMIT;
         idx_d   = idx_q + IW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         per_q   <= '0;
         idx_q   <= '0;
         msg_q   <= '0;
         len_q   <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= inc ? cnt_q + CNT_W'(1) : cnt_q;
         per_q   <= !inc ? per_q : evt ? '0 : per_q + CNT_W'(1);
         idx_q   <= idx_d;
         msg_q   <= msg_d;
         len_q   <= len_d;
         ovr_q   <= ovr_q | (evt && state_q != IDLE);
      end
   end

endmodule
